// File: rtl/cpu_jtag_debug_scan_master.sv
// Initiator end of the CPU debug virtual-JTAG interface: runs one full
// IR-update / capture / DR-shift / update / run-test-idle sequence per command
// and returns the bits shifted out of the slave.
// Optional IR cache: define CPU_JTAG_SCAN_IR_CACHE_EN to skip UIR when the
// requested IR matches the IR of the last completed scan.
module cpu_jtag_debug_scan_master #(
  parameter int unsigned TCK_DIV    = 4,
  parameter int unsigned DR_WIDTH   = 38,
  parameter int unsigned RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [1:0]          rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  input  logic [1:0]          vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned CW   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int unsigned PMAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  // S_START is a lead-in tck period with all flags low so the slave sees a
  // clean tck low/high before the first state flag is presented.
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI
  } state_t;

  state_t              state;
  logic [CW-1:0]       div_cnt;
  logic [PW-1:0]       per_cnt;
  logic [DR_WIDTH-1:0] shreg;
  logic [1:0]          ir_lat;
  logic [1:0]          ir_cap;
  logic                half_end;
  logic                low_start;
  logic                high_start;
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
  logic [1:0]          last_ir;
  logic                last_ir_vld;
  logic                skip_uir;
`endif

  // Half-period boundaries of the generated tck
  assign half_end   = (div_cnt == CW'(TCK_DIV - 1));
  assign low_start  = half_end & vji_tck;
  assign high_start = half_end & ~vji_tck;

  // Scan sequencer, tck divider, shift register and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      per_cnt    <= '0;
      shreg      <= '0;
      ir_lat     <= '0;
      ir_cap     <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
      last_ir     <= '0;
      last_ir_vld <= 1'b0;
      skip_uir    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          vji_tck <= 1'b0;
          if (rsp_valid) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            ir_lat    <= cmd_ir;
            shreg     <= cmd_dr;
            state     <= S_START;
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
            skip_uir  <= last_ir_vld && (cmd_ir == last_ir);
`endif
          end
        end
        default: begin
          if (half_end) begin
            div_cnt <= '0;
            vji_tck <= ~vji_tck;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end

          if (high_start) begin
            if (state == S_UIR) ir_cap <= vji_ir_out;
            if (state == S_SDR) shreg <= {vji_tdo, shreg[DR_WIDTH-1:1]};
          end

          if (low_start) begin
            case (state)
              S_START: begin
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
                if (skip_uir) begin
                  state   <= S_CDR;
                  vji_cdr <= 1'b1;
                end else begin
                  state     <= S_UIR;
                  vji_uir   <= 1'b1;
                  vji_ir_in <= ir_lat;
                end
`else
                state     <= S_UIR;
                vji_uir   <= 1'b1;
                vji_ir_in <= ir_lat;
`endif
              end
              S_UIR: begin
                state   <= S_CDR;
                vji_uir <= 1'b0;
                vji_cdr <= 1'b1;
              end
              S_CDR: begin
                state   <= S_SDR;
                vji_cdr <= 1'b0;
                vji_sdr <= 1'b1;
                vji_tdi <= shreg[0];
                per_cnt <= '0;
              end
              S_SDR: begin
                if (per_cnt == PW'(DR_WIDTH - 1)) begin
                  state   <= S_UDR;
                  vji_sdr <= 1'b0;
                  vji_udr <= 1'b1;
                  vji_tdi <= 1'b0;
                end else begin
                  per_cnt <= per_cnt + PW'(1);
                  vji_tdi <= shreg[0];
                end
              end
              S_UDR: begin
                state   <= S_RTI;
                vji_udr <= 1'b0;
                vji_rti <= 1'b1;
                per_cnt <= '0;
              end
              S_RTI: begin
                if (per_cnt == PW'(RTI_CYCLES - 1)) begin
                  state      <= S_IDLE;
                  vji_rti    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_dr     <= shreg;
                  rsp_ir_out <= ir_cap;
`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
                  last_ir     <= ir_lat;
                  last_ir_vld <= 1'b1;
`endif
                end else begin
                  per_cnt <= per_cnt + PW'(1);
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_jtag_debug_scan_master.sv
// Directed bench for cpu_jtag_debug_scan_master with a small virtual-JTAG
// slave model (tdi loopback flop or constant tdo pattern).
// Define CPU_JTAG_SCAN_IR_CACHE_EN to also exercise the IR cache.
module tb_cpu_jtag_debug_scan_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_dr;
  logic        rsp_valid;
  logic [37:0] rsp_dr;
  logic [1:0]  rsp_ir_out;
  logic        vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  vji_ir_in, vji_ir_out;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  cpu_jtag_debug_scan_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  // Slave model: loopback flop or constant pattern indexed by SDR bit
  logic        loop_mode = 1'b1;
  logic        lb_ff = 1'b0;
  logic [37:0] pat = '0;
  logic [5:0]  sdr_idx = '0;
  logic [1:0]  slave_ir_out = '0;

  always @(posedge vji_tck) begin
    if (vji_sdr) begin
      lb_ff   <= vji_tdi;
      sdr_idx <= sdr_idx + 6'd1;
    end else if (vji_cdr) begin
      lb_ff   <= 1'b0;
      sdr_idx <= '0;
    end
  end

  assign vji_tdo    = loop_mode ? lb_ff : ((sdr_idx < 6'd38) ? pat[sdr_idx] : 1'b0);
  assign vji_ir_out = slave_ir_out;

  // Monitor: flag occupancy, flag sequence, one-hot, IR stability, handshakes
  int         flag_cyc [5];
  logic [4:0] seq [$];
  logic [4:0] prev_code = '0;
  int         onehot_err = 0;
  int         ir_viol = 0;
  int         rsp_cnt = 0;
  int         acc_cnt = 0;
  logic [1:0] exp_ir_in = '0;

  always @(negedge clk) begin
    logic [4:0] code;
    code = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
    for (int i = 0; i < 5; i++) if (code[4-i]) flag_cyc[i]++;
    if (code != prev_code) begin
      seq.push_back(code);
      prev_code = code;
    end
    if (code != 5'd0 && !$onehot(code)) onehot_err++;
    if (code != 5'd0 && vji_ir_in != exp_ir_in) ir_viol++;
    if (rsp_valid) rsp_cnt++;
    if (cmd_valid && cmd_ready) acc_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 5; i++) flag_cyc[i] = 0;
    seq.delete();
    prev_code  = '0;
    onehot_err = 0;
    ir_viol    = 0;
  endtask

  function automatic logic [63:0] seq_word();
    logic [63:0] w;
    w = '0;
    foreach (seq[i]) w = {w[58:0], seq[i]};
    return w;
  endfunction

  function automatic logic [63:0] cyc_word();
    return {4'd0, 12'(flag_cyc[0]), 12'(flag_cyc[1]), 12'(flag_cyc[2]),
            12'(flag_cyc[3]), 12'(flag_cyc[4])};
  endfunction

  // One scan from the posedge+1 phase; returns clk edges from accept to rsp_valid
  task automatic do_scan(input logic [1:0] ir, input logic [37:0] dr, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
    exp_ir_in = ir;
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    clear_mon();
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    @(posedge clk); #1;
    check("ready_after_rsp", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] dr;
    logic        loop;
    logic [37:0] pat;
    logic [1:0]  ir_out;
    logic [37:0] exp_dr;
    logic [1:0]  exp_ir;
  } vec_t;

  vec_t vt [5];

  localparam logic [63:0] EXP_SEQ = 64'({5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h00});
  localparam logic [63:0] EXP_CYC = 64'({12'd8, 12'd8, 12'd304, 12'd8, 12'd16});

  initial begin
    int          lat;
    int          n;
    int          viol;
    logic [37:0] a, b;

    vt[0] = '{2'b01, 38'h2A_DEAD_BEEF, 1'b1, 38'h0,           2'b11, 38'h15_BD5B_7DDE, 2'b11};
    vt[1] = '{2'b00, 38'h0,            1'b0, 38'h15_5555_5555, 2'b10, 38'h15_5555_5555, 2'b10};
    vt[2] = '{2'b10, 38'h3F_FFFF_FFFF, 1'b1, 38'h0,           2'b01, 38'h3F_FFFF_FFFE, 2'b01};
    vt[3] = '{2'b11, 38'h12_3456_789A, 1'b0, 38'h0,           2'b00, 38'h0,            2'b00};
    vt[4] = '{2'b01, 38'h0,            1'b0, 38'h20_0000_0001, 2'b01, 38'h20_0000_0001, 2'b01};

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    rsp_cnt = 0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b1 ||
          {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 9'd0)
        viol++;
    end
    @(posedge clk); #1;
    check("idle_ready", cmd_ready, 1'b1);
    check("idle_vji", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 9'd0);
    check("idle_outputs", {rsp_valid, rsp_dr, rsp_ir_out}, 41'd0);
    check("idle_violations", viol, 0);
    check("idle_rsp_cnt", rsp_cnt, 0);

    // Table-driven scans
    for (int i = 0; i < 5; i++) begin
      loop_mode    = vt[i].loop;
      pat          = vt[i].pat;
      slave_ir_out = vt[i].ir_out;
      do_scan(vt[i].ir, vt[i].dr, lat);
      check($sformatf("v%0d_latency", i), lat, 352);
      check($sformatf("v%0d_rsp_dr", i), rsp_dr, vt[i].exp_dr);
      check($sformatf("v%0d_rsp_ir_out", i), rsp_ir_out, vt[i].exp_ir);
      check($sformatf("v%0d_flag_seq", i), seq_word(), EXP_SEQ);
      check($sformatf("v%0d_flag_cycles", i), cyc_word(), EXP_CYC);
      check($sformatf("v%0d_onehot", i), onehot_err, 0);
      check($sformatf("v%0d_ir_in", i), {ir_viol, vji_ir_in}, {32'd0, vt[i].ir});
    end

    // cmd_valid held through a scan with changing payload
    loop_mode = 1'b1;
    slave_ir_out = 2'b10;
    a = 38'h01_2345_6789;
    b = 38'h3C_0F0F_00FF;
    acc_cnt = 0;
    ir_viol = 0;
    exp_ir_in = 2'b10;
    cmd_ir = 2'b10; cmd_dr = a; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_ir = 2'b01; cmd_dr = b;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    check("held_first_dr", rsp_dr, {a[36:0], 1'b0});
    check("held_accepts_first", acc_cnt, 1);
    exp_ir_in = 2'b01;
    slave_ir_out = 2'b11;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (cmd_ready && n < 10);
    check("held_second_accept", {n > 1, cmd_ready}, 2'b10);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    check("held_second_dr", rsp_dr, {b[36:0], 1'b0});
    check("held_second_ir", rsp_ir_out, 2'b11);
    check("held_accepts_total", acc_cnt, 2);
    check("held_ir_in_stable", ir_viol, 0);
    @(posedge clk); #1;

    // Asynchronous reset during SDR bit 17
    pat = 38'h2A_AAAA_AAAA;
    loop_mode = 1'b0;
    exp_ir_in = 2'b10;
    cmd_ir = 2'b10; cmd_dr = 38'h1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(vji_sdr && sdr_idx == 6'd17) && n < 2000) begin @(negedge clk); n++; end
    check("rst_reached_bit17", {vji_sdr, sdr_idx}, {1'b1, 6'd17});
    #1 reset = 1'b1;
    #1;
    check("rst_flags_async", {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 7'd0);
    check("rst_ready_async", {cmd_ready, rsp_valid}, 2'b10);
    rsp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("rst_no_rsp", rsp_cnt, 0);
    do_scan(2'b10, 38'h0, lat);
    check("rst_next_latency", lat, 352);
    check("rst_next_dr", rsp_dr, 38'h2A_AAAA_AAAA);

`ifdef CPU_JTAG_SCAN_IR_CACHE_EN
    // IR cache: repeated IR skips UIR
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    loop_mode = 1'b0;
    pat = 38'h0F_0000_00F0;
    slave_ir_out = 2'b01;
    do_scan(2'b11, 38'h0, lat);
    check("cache_first_latency", lat, 352);
    check("cache_first_ir_out", rsp_ir_out, 2'b01);
    slave_ir_out = 2'b10;
    do_scan(2'b11, 38'h0, lat);
    check("cache_hit_latency", lat, 344);
    check("cache_hit_uir_cycles", flag_cyc[0], 0);
    check("cache_hit_ir_out", rsp_ir_out, 2'b01);
    check("cache_hit_dr", rsp_dr, 38'h0F_0000_00F0);
    do_scan(2'b00, 38'h0, lat);
    check("cache_miss_latency", lat, 352);
    check("cache_miss_uir_cycles", flag_cyc[0], 8);
    check("cache_miss_ir_out", rsp_ir_out, 2'b10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_jtag_debug_scan_master.md
Name: cpu_jtag_debug_scan_master

Overview:
- Synthesizable initiator end of the CPU JTAG debug virtual-JTAG interface.
- Generates the vji_* signal sequence that the debug module's tck-domain logic consumes: IR update, capture, a 38-bit shift and update.
- Used on-chip for self-test and in the bench to drive the debug module without a hardware JTAG hub.
- Accepts scan commands on a valid/ready port and returns the captured 38-bit shift-out data.

Parameters:
- TCK_DIV, 4: clk cycles per tck half-period; minimum 1. One tck period = 2*TCK_DIV clk cycles.
- DR_WIDTH, 38: data-register scan length in bits.
- RTI_CYCLES, 2: tck periods spent in run-test-idle after each update.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  scan command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_ir  in  2  IR value for the scan
- cmd_dr  in  DR_WIDTH  data shifted in, LSB first
- rsp_valid  out  1  one-clk pulse, scan complete
- rsp_dr  out  DR_WIDTH  data shifted out of vji_tdo
- rsp_ir_out  out  2  vji_ir_out sampled during UIR
- vji_tck  out  1  generated test clock
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  2  IR presented to slave
- vji_ir_out  in  2  IR status from slave
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state flags

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; FSM=IDLE; tck divider cleared.
- tck generation:
  - Free-running divider while FSM != IDLE; vji_tck=0 in IDLE.
  - Each tck period is a low half followed by a high half.
  - All state flags, vji_tdi and vji_ir_in change only at the clk edge that starts a low half.
  - vji_tdo and vji_ir_out are sampled at the clk edge that starts a high half.
- FSM states: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> IDLE.
  - IDLE: cmd_ready=1. On accept, latch cmd_ir/cmd_dr, drop cmd_ready, go UIR at the next low-half start.
  - UIR: 1 tck period; vji_uir=1; vji_ir_in=latched IR, held until the next command. rsp_ir_out captured on the rising half.
  - CDR: 1 tck period; vji_cdr=1.
  - SDR: exactly DR_WIDTH tck periods; vji_sdr=1; vji_tdi = shift-register bit 0.
    - Each rising half: capture vji_tdo into a shift register; shift right with tdo entering at MSB.
    - After DR_WIDTH bits: rsp_dr = original tdo bit order, bit0 = first tdo sampled.
  - UDR: 1 tck period; vji_udr=1.
  - RTI: RTI_CYCLES tck periods; vji_rti=1. On exit, rsp_valid pulses 1 clk with rsp_dr/rsp_ir_out stable; next cycle cmd_ready=1.
- Exactly one state flag is high outside IDLE; none in IDLE.
- Latency, accept to rsp_valid: (4+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk cycles. Defaults: 44*8 = 352.
- cmd_valid while busy is ignored and not stored. rsp_dr/rsp_ir_out hold until the next rsp_valid.
- Asynchronous reset mid-scan: immediate IDLE, flags 0, no rsp_valid, partial data discarded.
- TCK_DIV=1: tck toggles every clk; the behaviour above is otherwise unchanged.

Optional Feature:
- CPU_JTAG_SCAN_IR_CACHE_EN
- Defined: block keeps last_ir, valid after the first completed scan and cleared by reset. If cmd_ir equals last_ir, UIR is skipped: IDLE -> CDR directly, latency is one tck period shorter, and rsp_ir_out keeps its previous value.
- Undefined: UIR is always executed.

Test Plan:
- Reset then idle 20 clks -> cmd_ready=1, all vji_* 0, rsp_valid never asserted.
- Defaults; cmd_ir=2'b01, cmd_dr=38'h2A_DEAD_BEEF; loop vji_tdi to vji_tdo through one tck-flop model -> rsp_valid exactly 352 clks after accept, sequence uir/cdr/38x sdr/udr/2x rti, rsp_dr = cmd_dr shifted by one with first bit 0.
- Slave model drives vji_tdo from constant 38'h15_5555_5555 and vji_ir_out=2'b10 -> rsp_dr=38'h15_5555_5555, rsp_ir_out=2'b10.
- cmd_valid held high through a scan with changing data -> only the first command is executed; second accepted only after rsp_valid; vji_ir_in stable during each scan.
- Reset asserted at SDR bit 17 -> all flags low asynchronously, no rsp_valid; next command completes normally.
- With CPU_JTAG_SCAN_IR_CACHE_EN, two scans with IR 2'b11 -> second has no vji_uir pulse and latency 344 clks; a third scan with IR 2'b00 includes UIR.
